// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one req/ack/data target port between N_REQ requesters.
// One transfer per grant, followed by a release phase that waits for the target ack to drop.
module req_ack_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]            ack_o,
    output logic                        req_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    input  logic                        ack_i,
    output logic                        gnt_valid_o,
    output logic [IDX_W-1:0]            gnt_idx_o,
    output logic [15:0]                 xfer_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] idx_after_gnt;

    // Walk offsets from the highest down so the lowest offset from rr_ptr wins.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = (int'(rr_ptr_q) + i) % N_REQ;
            if (req_i[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    assign idx_after_gnt = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_cnt_d  = xfer_cnt_q;
        case (state_q)
            IDLE: begin
                req_d       = 1'b0;
                gnt_valid_d = 1'b0;
                if (pick_found) begin
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    req_d       = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Owner dropping its request ends the grant uncounted, even if ack arrives with it.
                if (!req_i[gnt_idx_q] || ack_i) begin
                    if (req_i[gnt_idx_q]) begin
                        xfer_cnt_d = xfer_cnt_q + 16'd1;
                    end
                    rr_ptr_d    = idx_after_gnt;
                    req_d       = 1'b0;
                    gnt_valid_d = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                req_d       = 1'b0;
                gnt_valid_d = 1'b0;
                if (!ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d       = 1'b0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            rr_ptr_q    <= '0;
            xfer_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_q == GRANT && ack_i) begin
            ack_o[gnt_idx_q] = 1'b1;
        end
    end

    assign data_o      = data_i[int'(gnt_idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign req_o       = req_q;
    assign gnt_valid_o = gnt_valid_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign xfer_cnt_o  = xfer_cnt_q;

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Directed vector bench for req_ack_arbiter with two requesters; the target ack is
// driven by hand as the registered copy of req_o.
module tb_req_ack_arbiter;

    localparam int N_REQ = 2;
    localparam int DW    = 8;
    localparam int IW    = 1;

    logic              clk;
    logic              rst;
    logic [N_REQ-1:0]  req_i;
    logic [N_REQ*DW-1:0] data_i;
    logic [N_REQ-1:0]  ack_o;
    logic              req_o;
    logic [DW-1:0]     data_o;
    logic              ack_i;
    logic              gnt_valid_o;
    logic [IW-1:0]     gnt_idx_o;
    logic [15:0]       xfer_cnt_o;

    int checks;
    int errors;

    req_ack_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .req_o       (req_o),
        .data_o      (data_o),
        .ack_i       (ack_i),
        .gnt_valid_o (gnt_valid_o),
        .gnt_idx_o   (gnt_idx_o),
        .xfer_cnt_o  (xfer_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        ack;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        e_req;
        logic        e_gv;
        logic        e_idx;
        logic [1:0]  e_ack;
        logic [15:0] e_cnt;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] rq, input logic a,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic er, input logic eg, input logic ei,
                       input logic [1:0] ea, input logic [15:0] ec, input logic [7:0] ed);
        vec_t v;
        v.rst = r; v.req = rq; v.ack = a; v.d0 = d0; v.d1 = d1;
        v.e_req = er; v.e_gv = eg; v.e_idx = ei; v.e_ack = ea; v.e_cnt = ec; v.e_data = ed;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req_i  = '0;
        ack_i  = 1'b0;
        data_i = {8'h00, 8'h5A};

        // Each row: inputs held for one cycle; expectations are what the DUT shows in that cycle.
        //   rst req  ack d0     d1     req gv idx ack_o cnt    data
        // single requester
        add(0, 2'b01, 0, 8'h5A, 8'h00, 0, 0, 0, 2'b00, 16'd0, 8'h5A);
        add(0, 2'b01, 0, 8'h5A, 8'h00, 1, 1, 0, 2'b00, 16'd0, 8'h5A);
        add(0, 2'b01, 1, 8'h5A, 8'h00, 1, 1, 0, 2'b01, 16'd0, 8'h5A);
        add(0, 2'b00, 1, 8'h5A, 8'h00, 0, 0, 0, 2'b00, 16'd1, 8'h5A);
        add(0, 2'b00, 0, 8'h5A, 8'h00, 0, 0, 0, 2'b00, 16'd1, 8'h5A);
        // requester 1 alone (rr_ptr is 1 here)
        add(0, 2'b10, 0, 8'h5A, 8'h33, 0, 0, 0, 2'b00, 16'd1, 8'h5A);
        add(0, 2'b10, 0, 8'h5A, 8'h33, 1, 1, 1, 2'b00, 16'd1, 8'h33);
        add(0, 2'b10, 1, 8'h5A, 8'h33, 1, 1, 1, 2'b10, 16'd1, 8'h33);
        // both request: after the wrap, 0 wins, then alternate
        add(0, 2'b11, 1, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd2, 8'h22);
        add(0, 2'b11, 0, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd2, 8'h22);
        add(0, 2'b11, 0, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd2, 8'h22);
        add(0, 2'b11, 0, 8'h11, 8'h22, 1, 1, 0, 2'b00, 16'd2, 8'h11);
        add(0, 2'b11, 1, 8'h11, 8'h22, 1, 1, 0, 2'b01, 16'd2, 8'h11);
        add(0, 2'b11, 1, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd3, 8'h11);
        add(0, 2'b11, 0, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd3, 8'h11);
        add(0, 2'b11, 0, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd3, 8'h11);
        add(0, 2'b11, 0, 8'h11, 8'h22, 1, 1, 1, 2'b00, 16'd3, 8'h22);
        add(0, 2'b11, 1, 8'h11, 8'h22, 1, 1, 1, 2'b10, 16'd3, 8'h22);
        add(0, 2'b11, 1, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd4, 8'h22);
        add(0, 2'b11, 0, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd4, 8'h22);
        add(0, 2'b11, 0, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd4, 8'h22);
        // abort: requester 0 drops before ack, then 1 is granted (ack high in IDLE ignored)
        add(0, 2'b11, 0, 8'h11, 8'h22, 1, 1, 0, 2'b00, 16'd4, 8'h11);
        add(0, 2'b10, 0, 8'h11, 8'h22, 1, 1, 0, 2'b00, 16'd4, 8'h11);
        add(0, 2'b10, 1, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd4, 8'h11);
        add(0, 2'b10, 0, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd4, 8'h11);
        add(0, 2'b10, 1, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd4, 8'h11);
        add(0, 2'b10, 0, 8'h11, 8'h22, 1, 1, 1, 2'b00, 16'd4, 8'h22);
        add(0, 2'b10, 1, 8'h11, 8'h22, 1, 1, 1, 2'b10, 16'd4, 8'h22);
        add(0, 2'b00, 1, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd5, 8'h22);
        add(0, 2'b00, 0, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd5, 8'h22);
        // reset mid-GRANT with ack high: no count, rr_ptr back to 0
        add(0, 2'b01, 0, 8'h11, 8'h22, 0, 0, 1, 2'b00, 16'd5, 8'h22);
        add(0, 2'b01, 0, 8'h11, 8'h22, 1, 1, 0, 2'b00, 16'd5, 8'h11);
        add(0, 2'b01, 1, 8'h11, 8'h22, 1, 1, 0, 2'b01, 16'd5, 8'h11);
        add(0, 2'b11, 1, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd6, 8'h11);
        add(0, 2'b11, 0, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd6, 8'h11);
        add(0, 2'b11, 0, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd6, 8'h11);
        add(0, 2'b11, 0, 8'h11, 8'h22, 1, 1, 1, 2'b00, 16'd6, 8'h22);
        add(1, 2'b11, 1, 8'h11, 8'h22, 1, 1, 1, 2'b10, 16'd6, 8'h22);
        add(0, 2'b11, 1, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd0, 8'h11);
        add(0, 2'b11, 0, 8'h11, 8'h22, 1, 1, 0, 2'b00, 16'd0, 8'h11);
        add(0, 2'b11, 1, 8'h11, 8'h22, 1, 1, 0, 2'b01, 16'd0, 8'h11);
        add(0, 2'b00, 1, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd1, 8'h11);
        add(0, 2'b00, 0, 8'h11, 8'h22, 0, 0, 0, 2'b00, 16'd1, 8'h11);

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_req_o", 32'(req_o), 32'd0);
        chk("reset_gnt_valid", 32'(gnt_valid_o), 32'd0);
        chk("reset_gnt_idx", 32'(gnt_idx_o), 32'd0);
        chk("reset_xfer_cnt", 32'(xfer_cnt_o), 32'd0);
        chk("reset_ack_o", 32'(ack_o), 32'd0);
        chk("reset_data_o", 32'(data_o), 32'h5A);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            req_i  = vecs[i].req;
            ack_i  = vecs[i].ack;
            data_i = {vecs[i].d1, vecs[i].d0};
            #1;
            chk($sformatf("v%0d_req_o", i), 32'(req_o), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_gnt_valid", i), 32'(gnt_valid_o), 32'(vecs[i].e_gv));
            chk($sformatf("v%0d_gnt_idx", i), 32'(gnt_idx_o), 32'(vecs[i].e_idx));
            chk($sformatf("v%0d_ack_o", i), 32'(ack_o), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d_xfer_cnt", i), 32'(xfer_cnt_o), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_data_o", i), 32'(data_o), 32'(vecs[i].e_data));
            tick();
        end
        rst = 1'b0;

        // Counter wrap: preload 0xFFFF, one more transfer must give 0.
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        release dut.xfer_cnt_q;
        req_i = 2'b01;
        ack_i = 1'b0;
        tick();
        chk("wrap_grant_req_o", 32'(req_o), 32'd1);
        ack_i = 1'b1;
        #1;
        chk("wrap_ack_o", 32'(ack_o), 32'b01);
        tick();
        req_i = 2'b00;
        #1;
        chk("wrap_xfer_cnt", 32'(xfer_cnt_o), 32'd0);
        chk("wrap_req_o_low", 32'(req_o), 32'd0);
        ack_i = 1'b0;
        tick();
        tick();
        chk("wrap_idle_gnt_valid", 32'(gnt_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
